// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared state encoding and width helpers for the neuron layer
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Accumulator width: a 16-bit product summed N times cannot exceed this.
  function automatic int acc_width(input int n);
    return 16 + clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed 8x8 multiply-accumulate with synchronous clear and enable
module mac_unit #(
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [7:0]       x,
  input  logic signed [7:0]       w,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Product is sign-extended up to the accumulator width before summing.
  always_comb begin
    prod  = x * w;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-16){prod[15]}}, prod};
    end
  end

  // Accumulator register; clear takes priority over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/neuron_layer_ctrl.sv
// rtl/neuron_layer_ctrl.sv - sequences one fully connected layer pass with ReLU output handshake
module neuron_layer_ctrl
  import neuron_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int M     = 4,
  localparam int ACC_W = acc_width(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       x_adr,
  output logic [31:0]       w_adr,
  input  logic signed [7:0] x,
  input  logic signed [7:0] w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_idx,
  output logic [ACC_W-1:0]  out_data
);

  state_t      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [31:0] xa_q, xa_d;
  logic [31:0] wa_q, wa_d;
  logic [31:0] cur_x_adr;
  logic [31:0] cur_w_adr;
  logic        mac_clr;
  logic        mac_en;
  logic signed [ACC_W-1:0] acc;

  assign cur_x_adr = 32'(i_q);
  assign cur_w_adr = 32'(j_q) * 32'(N) + 32'(i_q);

  mac_unit #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .x   (x),
    .w   (w),
    .acc (acc)
  );

  // Next-state, counter and accumulator-control decode.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    xa_d    = xa_q;
    wa_d    = wa_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        xa_d   = cur_x_adr;
        wa_d   = cur_w_adr;
        if (i_q == 8'(N - 1)) begin
          state_d = OUT;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (j_q == 8'(M - 1)) begin
            state_d = DONE;
          end else begin
            state_d = MAC;
            j_d     = j_q + 8'd1;
            i_d     = '0;
            mac_clr = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and held addresses; reset drops any pass in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      xa_q    <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      xa_q    <= xa_d;
      wa_q    <= wa_d;
    end
  end

  // Addresses track the counters in MAC and freeze at their last value elsewhere.
  assign x_adr     = (state_q == MAC) ? cur_x_adr : xa_q;
  assign w_adr     = (state_q == MAC) ? cur_w_adr : wa_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == OUT);
  assign out_idx   = j_q;
  assign out_data  = (state_q == OUT && !acc[ACC_W-1]) ? acc : '0;

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// tb/tb_neuron_layer_ctrl.sv - scoreboard bench for neuron_layer_ctrl with N=3, M=2
module tb_neuron_layer_ctrl;

  localparam int N = 3;
  localparam int M = 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [31:0]       x_adr;
  logic [31:0]       w_adr;
  logic signed [7:0] x;
  logic signed [7:0] w;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_idx;
  logic [17:0]       out_data;

  logic signed [7:0] x_mem [N];
  logic signed [7:0] w_mem [N*M];

  int total;
  int bad;
  int done_cnt;
  int exp_idx_q[$];
  int exp_data_q[$];
  logic [31:0] wlog_q[$];
  bit log_en;

  neuron_layer_ctrl #(
    .N(N),
    .M(M)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .x_adr     (x_adr),
    .w_adr     (w_adr),
    .x         (x),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read memories.
  always_comb begin
    x = 8'sd0;
    w = 8'sd0;
    if (x_adr < 32'(N)) x = x_mem[x_adr[1:0]];
    if (w_adr < 32'(N*M)) w = w_mem[w_adr[2:0]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard pop on each accepted result; also counts done pulses and logs MAC addresses.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_idx_q.size() == 0) begin
          check("unexpected_result", 64'(out_idx), 64'hFFFF);
        end else begin
          check("out_idx", 64'(out_idx), 64'(exp_idx_q.pop_front()));
          check("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
        end
      end
      if (done) done_cnt++;
      if (log_en && busy && !out_valid && !done) wlog_q.push_back(w_adr);
    end
  end

  task automatic push_expected();
    for (int j = 0; j < M; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(x_mem[i]) * int'(w_mem[j*N+i]);
      if (s < 0) s = 0;
      exp_idx_q.push_back(j);
      exp_data_q.push_back(s);
    end
  endtask

  task automatic load(input int xv0, input int xv1, input int xv2, input int wr0, input int wr1);
    x_mem[0] = 8'(xv0);
    x_mem[1] = 8'(xv1);
    x_mem[2] = 8'(xv2);
    for (int i = 0; i < N; i++) begin
      w_mem[i]     = 8'(wr0);
      w_mem[N + i] = 8'(wr1);
    end
  endtask

  // One full pass: latency check, optional 5-cycle backpressure on the first result.
  task automatic run_pass(input bit bp);
    int cnt;
    int d0;
    push_expected();
    d0 = done_cnt;
    out_ready = !bp;
    @(posedge clk);
    #1 start = 1'b1;
    cnt = 0;
    while (cnt < 50) begin
      @(posedge clk);
      #1;
      if (cnt == 0) start = 1'b0;
      cnt++;
      if (out_valid) break;
    end
    check("latency", 64'(cnt), 64'(N + 1));
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_idx", 64'(out_idx), 64'(exp_idx_q[0]));
        check("bp_data", 64'(out_data), 64'(exp_data_q[0]));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
    end
    cnt = 0;
    while (done_cnt == d0 && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("queue_empty", 64'(exp_idx_q.size()), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int cnt;
    total = 0;
    bad = 0;
    done_cnt = 0;
    log_en = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    load(1, 2, 3, 1, -1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_xadr", 64'(x_adr), 64'd0);
    check("rst_wadr", 64'(w_adr), 64'd0);
    rst = 1'b1;

    // basic layer: 6 then ReLU(-6)=0
    run_pass(1'b0);

    // backpressure on first result
    run_pass(1'b1);

    // extreme values: 3*16384 per neuron
    load(-128, -128, -128, -128, -128);
    check("extreme_model", 64'(3 * int'(x_mem[0]) * int'(w_mem[0])), 64'd49152);
    run_pass(1'b0);

    // start pulsed mid-MAC must not restart; address sequence 0..5
    load(1, 2, 3, 1, -1);
    wlog_q.delete();
    log_en = 1'b1;
    fork
      run_pass(1'b0);
      begin
        repeat (3) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
      end
    join
    log_en = 1'b0;
    check("wlog_len", 64'(wlog_q.size()), 64'd6);
    for (int k = 0; k < 6 && k < wlog_q.size(); k++) check("wlog_adr", 64'(wlog_q[k]), 64'(k));

    // reset during MAC of neuron 1
    push_expected();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    while (!(busy && !out_valid && w_adr == 32'd4) && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("reach_neuron1", 64'(w_adr), 64'd4);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_idx", 64'(out_idx), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_xadr", 64'(x_adr), 64'd0);
    check("arst_wadr", 64'(w_adr), 64'd0);
    exp_idx_q.delete();
    exp_data_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(busy), 64'd0);
    run_pass(1'b0);

    // a few random passes
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) x_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < N*M; i++) w_mem[i] = 8'($urandom_range(0, 255));
      run_pass(r == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_layer_ctrl.md
NEURON_LAYER_CTRL -- requirements
Module: neuron_layer_ctrl

Interface
REQ-001 SHALL have parameter N, default 3: number of inputs per neuron, range 1..256.
REQ-002 SHALL have parameter M, default 4: number of neurons in the layer, range 1..256.
REQ-003 SHALL define local width ACC_W = 16 + clog2(N+1) for the accumulator and output data.
REQ-004 SHALL use a single clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: begin one layer pass; sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse after the last neuron's result is accepted.
REQ-010 SHALL have port x_adr, output, 32 bits: input-memory address; combinational-read memory.
REQ-011 SHALL have port w_adr, output, 32 bits: weight-memory address; combinational-read memory.
REQ-012 SHALL have port x, input, 8 bits: signed input read from x_adr in the same cycle.
REQ-013 SHALL have port w, input, 8 bits: signed weight read from w_adr in the same cycle.
REQ-014 SHALL have port out_valid, output, 1 bit: result available.
REQ-015 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-016 SHALL have port out_idx, output, 8 bits: neuron index j of the current result.
REQ-017 SHALL have port out_data, output, ACC_W bits: ReLU of neuron j's dot product, unsigned.

Function
REQ-018 SHALL implement the FSM states IDLE, MAC, OUT and DONE.
REQ-019 SHALL, in IDLE, move to MAC on start=1 with j=0, i=0 and acc=0; start is ignored in all other states.
REQ-020 SHALL, in MAC, drive x_adr=i and w_adr=j*N+i, and each cycle set acc <= acc + sext(x)*sext(w), a signed 16-bit product.
REQ-021 SHALL, in MAC, increment i while i<N-1; on the cycle with i==N-1, perform the final accumulate and move to OUT.
REQ-022 SHALL take exactly N cycles in MAC per neuron; first result out_valid rises N+1 cycles after the start edge.
REQ-023 SHALL, in OUT, drive out_valid=1, out_idx=j, and out_data = (acc<0) ? 0 : acc.
REQ-024 SHALL hold out_valid, out_idx and out_data stable until out_valid and out_ready are both high on a clock edge.
REQ-025 SHALL, on the OUT handshake with j<M-1, set j++, i=0 and acc=0 and return to MAC; with j==M-1, move to DONE.
REQ-026 SHALL, in DONE, assert done=1 for one cycle, then return to IDLE; out_valid=0 in DONE.
REQ-027 SHALL hold x_adr and w_adr at their last values outside MAC.
REQ-028 SHALL size acc at ACC_W bits signed so that it cannot overflow for any input values (worst case N*16384).
REQ-029 SHALL handle N==1: MAC lasts 1 cycle. SHALL handle M==1: DONE follows the first handshake.
REQ-030 SHALL allow out_ready to be held high continuously; the handshake then completes on the first OUT cycle.

Reset
REQ-031 SHALL, while rst=0 and regardless of clk, force state=IDLE, i=0, j=0 and acc=0.
REQ-032 SHALL, while rst=0, force busy=0, done=0, out_valid=0, out_idx=0, out_data=0, x_adr=0 and w_adr=0.
REQ-033 SHALL discard a pass interrupted by reset; after rst rises, wait for a new start.

Structure
REQ-034 SHALL place the state encoding (IDLE, MAC, OUT, DONE), the clog2 function and the ACC_W formula in a shared package, neuron_pkg.
REQ-035 SHALL instantiate one sub-module, mac_unit: signed 8x8 multiply-accumulate with synchronous clear and enable, parameterized by ACC_W.

Verification
REQ-036 Scenario, basic layer: N=3, M=2; x=[1,2,3]; w row0=[1,1,1], row1=[-1,-1,-1]; out_ready=1. Required: out_data=6 then 0 (ReLU); out_idx 0 then 1; done pulses once.
REQ-037 Scenario, backpressure: same data, out_ready=0 for 5 cycles in OUT. Required: out_valid, out_data=6 and out_idx=0 stable for all 5 cycles; the pass resumes after out_ready=1.
REQ-038 Scenario, extreme values: N=3, all x=-128, all w=-128. Required: out_data=49152 with ACC_W=18; no wrap.
REQ-039 Scenario, start while busy: pulse start mid-MAC. Required: no restart; address sequence 0,1,2 then 3,4,5 unchanged.
REQ-040 Scenario, reset mid-operation: assert rst=0 during MAC of neuron 1. Required: outputs are 0 immediately (asynchronously); after release, a new start yields correct results from j=0.
REQ-041 Scenario, latency check: N=3, start at edge t. Required: out_valid rises at edge t+4.
